// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, stall/flush/freeze controls, stall counter.
// Optional feature macro: HAZARD_FWD_EN (defined = operand forwarding + load-use stalls; undefined = RAW stalls, no forwarding).
module hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [RA_W-1:0]  ID_rs1,
   input  logic [RA_W-1:0]  ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic [RA_W-1:0]  EX_rs1,
   input  logic [RA_W-1:0]  EX_rs2,
   input  logic [RA_W-1:0]  EX_rd,
   input  logic             EX_reg_write,
   input  logic             EX_mem_read,
   input  logic [RA_W-1:0]  MEM_rd,
   input  logic             MEM_reg_write,
   input  logic [RA_W-1:0]  WB_rd,
   input  logic             WB_reg_write,
   input  logic             EX_br_taken,
   input  logic             MEM_req,
   input  logic             MEM_ready,
   input  logic             CNT_clr,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IDEX_write,
   output logic             EXMEM_write,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             MEMWB_bubble,
   output logic             PC_br_sel,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic [CNT_W-1:0] STALL_CNT
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t     state;
   logic       freeze;
   logic       br;
   logic       hit;
   logic       src1_v;
   logic       src2_v;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // Freeze is combinational so it asserts in the very cycle the memory first stalls.
   assign freeze = (state == MEM_WAIT) ? !MEM_ready : (MEM_req && !MEM_ready);
   assign br     = !freeze && EX_br_taken;

   assign src1_v = ID_use_rs1 && (ID_rs1 != '0);
   assign src2_v = ID_use_rs2 && (ID_rs2 != '0);

`ifdef HAZARD_FWD_EN
   logic unused_sigs;
   assign unused_sigs = EX_reg_write;

   assign hit = EX_mem_read && (EX_rd != '0) &&
                ((src1_v && (ID_rs1 == EX_rd)) || (src2_v && (ID_rs2 == EX_rd)));

   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
      if (MEM_reg_write && (MEM_rd != '0) && (MEM_rd == rs))
         return 2'b10;
      else if (WB_reg_write && (WB_rd != '0) && (WB_rd == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign fwd_a = fwd_sel(EX_rs1);
   assign fwd_b = fwd_sel(EX_rs2);
`else
   logic unused_sigs;
   assign unused_sigs = ^{EX_rs1, EX_rs2, EX_mem_read, WB_rd, WB_reg_write};

   // WB producers need no check: the register file writes on the opposite edge.
   logic ex_hit;
   logic mem_hit;
   assign ex_hit  = EX_reg_write &&
                    ((src1_v && (ID_rs1 == EX_rd)) || (src2_v && (ID_rs2 == EX_rd)));
   assign mem_hit = MEM_reg_write &&
                    ((src1_v && (ID_rs1 == MEM_rd)) || (src2_v && (ID_rs2 == MEM_rd)));
   assign hit     = ex_hit || mem_hit;
   assign fwd_a   = 2'b00;
   assign fwd_b   = 2'b00;
`endif

   // Priority: reset > freeze > branch > stall > normal.
   always_comb begin
      PC_write     = 1'b1;
      IFID_write   = 1'b1;
      IDEX_write   = 1'b1;
      EXMEM_write  = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      MEMWB_bubble = 1'b0;
      PC_br_sel    = 1'b0;
      forwardA     = fwd_a;
      forwardB     = fwd_b;
      if (!RSTn) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         IFID_flush   = 1'b1;
         IDEX_flush   = 1'b1;
         MEMWB_bubble = 1'b1;
         forwardA     = 2'b00;
         forwardB     = 2'b00;
      end else if (freeze) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         MEMWB_bubble = 1'b1;
      end else if (br) begin
         PC_br_sel    = 1'b1;
         IFID_flush   = 1'b1;
         IDEX_flush   = 1'b1;
      end else if (hit) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_flush   = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:      if (MEM_req && !MEM_ready) state <= MEM_WAIT;
            MEM_WAIT: if (MEM_ready)             state <= RUN;
            default:                             state <= RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         STALL_CNT <= '0;
      else if (CNT_clr)
         STALL_CNT <= '0;
      else if (!PC_write && (STALL_CNT != {CNT_W{1'b1}}))
         STALL_CNT <= STALL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage pipelined CPU. It drives the forwarding-mux selects for the two EX operands. It generates write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM, and holds the pipeline frozen while the data memory is not ready. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `RA_W`, 5, register-address width
- `CNT_W`, 16, stall counter width

Ports:
- `CLK`  in  1  clock; state and counter update on posedge
- `RSTn`  in  1  asynchronous active-low reset
- `ID_rs1`, `ID_rs2`  in  RA_W  source registers of the instruction in ID
- `ID_use_rs1`, `ID_use_rs2`  in  1  ID instruction actually reads rs1/rs2
- `EX_rs1`, `EX_rs2`  in  RA_W  source registers of the instruction in EX
- `EX_rd`  in  RA_W  destination register in EX; `EX_reg_write`, `EX_mem_read`  in  1
- `MEM_rd`  in  RA_W  destination register in MEM; `MEM_reg_write`  in  1
- `WB_rd`  in  RA_W  destination register in WB; `WB_reg_write`  in  1
- `EX_br_taken`  in  1  branch/jump resolved taken in EX
- `MEM_req`  in  1  data-memory access active in MEM
- `MEM_ready`  in  1  data memory completes this cycle
- `CNT_clr`  in  1  synchronous clear of `STALL_CNT`
- `PC_write`, `IFID_write`, `IDEX_write`, `EXMEM_write`  out  1  pipeline-register write enables
- `IFID_flush`, `IDEX_flush`, `MEMWB_bubble`  out  1  insert NOP into the register
- `PC_br_sel`  out  1  select the branch address into PC
- `forwardA`, `forwardB`  out  2  operand select: 00 = ID/EX value, 01 = WB result, 10 = EX/MEM ALU result
- `STALL_CNT`  out  CNT_W  stalled-cycle count

## Operation
- FSM has two states.
  - RUN → MEM_WAIT when `MEM_req && !MEM_ready`.
  - MEM_WAIT → RUN when `MEM_ready`.
  - Encoding is free.
- A freeze is active when the state is MEM_WAIT and `!MEM_ready`, or the state is RUN and `MEM_req && !MEM_ready`.
  - During a freeze, all four write enables are 0 and `MEMWB_bubble`=1.
  - All flushes are 0 and `PC_br_sel`=0.
- A branch applies when not frozen and `EX_br_taken`=1.
  - Outputs: `PC_br_sel`=1, `IFID_flush`=1, `IDEX_flush`=1; all writes 1.
  - A branch held in EX during a freeze takes effect in the release cycle.
- A load-use stall applies when not frozen, there is no branch, and `EX_mem_read && EX_rd!=0` matches a used ID source.
  - Outputs: `PC_write`=0, `IFID_write`=0, `IDEX_flush`=1; `IDEX_write`=1 and `EXMEM_write`=1.
- Priority: freeze > branch > load-use/RAW stall > normal.
- Normal operation: all writes 1, all flushes, bubble and `PC_br_sel` 0.
- Forwarding:
  - `forwardA`=10 if `MEM_reg_write && MEM_rd!=0 && MEM_rd==EX_rs1`.
  - Else `forwardA`=01 if the same condition holds for WB.
  - Else `forwardA`=00.
  - `forwardB` is identical using `EX_rs2`.
  - Register x0 never forwards.
- `STALL_CNT` increments on each posedge where `PC_write`=0 and `RSTn`=1.
  - Saturates at 2^CNT_W−1.
  - `CNT_clr` has priority over increment.

## Timing
- All controls except state and counter are combinational from inputs and state.
- Controls settle within the first half-cycle, because pipeline registers capture on negedge `CLK`.
- Freeze asserts in the same cycle `MEM_req && !MEM_ready` is seen, with zero latency.
- Release occurs in the cycle `MEM_ready`=1; the state is back in RUN on the next posedge.
- `MEM_ready`=1 in the first request cycle causes no freeze and no state change.
- Reset (`RSTn`=0, async, any time including mid-MEM_WAIT):
  - State goes to RUN and `STALL_CNT`=0 immediately.
  - While low: all write enables 0, `IFID_flush`=`IDEX_flush`=`MEMWB_bubble`=1, `PC_br_sel`=0, forwards 00.
- Deassertion takes effect at the next posedge `CLK`.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above; stalls occur only for load-use.
- `HAZARD_FWD_EN` undefined:
  - `forwardA`/`forwardB` are tied to 00.
  - A RAW stall replaces load-use. It applies when a used ID source (≠0) matches `EX_rd` with `EX_reg_write`, or `MEM_rd` with `MEM_reg_write`.
  - A RAW stall has the same outputs as a load-use stall.
  - No WB-stage check is made; the register file writes on the opposite edge.

## Test plan
- EX: `MEM_rd`=3, `MEM_reg_write`=1, `EX_rs1`=3; also `WB_rd`=3, `WB_reg_write`=1 → `forwardA`=10. Drop MEM → 01. Set rd=0 → 00.
- Load-use: `EX_mem_read`=1, `EX_rd`=5, `ID_rs2`=5, `ID_use_rs2`=1 → for one cycle `PC_write`=0, `IFID_write`=0, `IDEX_flush`=1. `STALL_CNT` goes 0→1.
- `MEM_req`=1, `MEM_ready`=0 for 3 cycles, then 1 → writes 0 and bubble=1 for 3 cycles, released in the 4th cycle. `STALL_CNT`=3; state RUN afterwards.
- `EX_br_taken`=1 during a freeze → `PC_br_sel`=0 while frozen; in the release cycle `PC_br_sel`=`IFID_flush`=`IDEX_flush`=1.
- `RSTn` pulsed low mid-MEM_WAIT → outputs immediately take their reset values. `STALL_CNT`=0. After release with `MEM_req`=0, normal operation resumes.
- `HAZARD_FWD_EN` undefined: `MEM_rd`=7, `MEM_reg_write`=1, `ID_rs1`=7, `ID_use_rs1`=1 → RAW stall asserted, forwards 00.
